// File: rtl/venom_anim_ctrl.sv
// Venom projectile animation sequencer: frame stepping, sprite ROM addressing, colour key.
// Define VENOM_LOOP_EN to loop the animation until stop instead of ending after FRAMES frames.
module venom_anim_ctrl #(
    parameter int FRAMES          = 8,
    parameter int FRAME_W         = 32,
    parameter int FRAME_H         = 32,
    parameter int TICKS_PER_FRAME = 4,
    parameter int ADDR_W          = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              fire,
    input  logic              stop,
    input  logic [9:0]        x_origin,
    input  logic [9:0]        y_origin,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_index,
    output logic [3:0]        pal_index,
    output logic              pixel_en,
    output logic              busy,
    output logic              done
);

    localparam int FRW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int FSZ = FRAME_W * FRAME_H;
    localparam logic [FRW-1:0] LAST_FRAME = FRW'(FRAMES - 1);
    localparam logic [7:0]     LAST_TICK  = 8'(TICKS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    state_t          state;
    logic [FRW-1:0]  frame;
    logic [7:0]      tick;
    logic [9:0]      x0;
    logic [9:0]      y0;
    logic            vld;

    logic            in_x;
    logic            in_y;
    logic            in_box;
    logic [9:0]      dx;
    logic [9:0]      dy;
    logic [ADDR_W-1:0] addr_next;
    logic            opaque;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            frame <= '0;
            tick  <= '0;
            x0    <= '0;
            y0    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        state <= PLAY;
                        busy  <= 1'b1;
                        x0    <= x_origin;
                        y0    <= y_origin;
                        frame <= '0;
                        tick  <= '0;
                    end
                end
                PLAY: begin
                    // stop wins over a coincident frame_start
                    if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (frame_start) begin
                        if (tick == LAST_TICK) begin
                            tick <= '0;
                            if (frame == LAST_FRAME) begin
`ifdef VENOM_LOOP_EN
                                frame <= '0;
`else
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                frame <= frame + 1'b1;
                            end
                        end else begin
                            tick <= tick + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // 11-bit compares keep boxes near the right/bottom edge from wrapping
    assign in_x = ({1'b0, DrawX} >= {1'b0, x0}) &&
                  ({1'b0, DrawX} <  ({1'b0, x0} + 11'(FRAME_W)));
    assign in_y = ({1'b0, DrawY} >= {1'b0, y0}) &&
                  ({1'b0, DrawY} <  ({1'b0, y0} + 11'(FRAME_H)));
    assign in_box = in_x && in_y;

    assign dx = DrawX - x0;
    assign dy = DrawY - y0;

    assign addr_next = ADDR_W'(32'(frame) * 32'(FSZ) +
                               32'(dy) * 32'(FRAME_W) +
                               32'(dx));

    assign opaque = (rom_index != 4'd0) && (rom_index != 4'd11);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            vld       <= 1'b0;
            pal_index <= '0;
            pixel_en  <= 1'b0;
        end else begin
            rom_addr  <= in_box ? addr_next : '0;
            vld       <= in_box && (state == PLAY);
            pal_index <= rom_index;
            pixel_en  <= vld && opaque;
        end
    end

endmodule

// File: tb/tb_venom_anim_ctrl.sv
// Directed bench for venom_anim_ctrl with a per-cycle reference model.
module tb_venom_anim_ctrl;

    localparam int FRAMES = 8;
    localparam int FW     = 32;
    localparam int FH     = 32;
    localparam int TPF    = 4;
    localparam int AW     = 13;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          frame_start;
    logic          fire;
    logic          stop;
    logic [9:0]    x_origin;
    logic [9:0]    y_origin;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_index;
    logic [3:0]    pal_index;
    logic          pixel_en;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;
    int got_addr;

    always #5 Clk = ~Clk;

    venom_anim_ctrl #(
        .FRAMES(FRAMES), .FRAME_W(FW), .FRAME_H(FH),
        .TICKS_PER_FRAME(TPF), .ADDR_W(AW)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .fire(fire), .stop(stop), .x_origin(x_origin), .y_origin(y_origin),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
        .rom_index(rom_index), .pal_index(pal_index), .pixel_en(pixel_en),
        .busy(busy), .done(done)
    );

    // Reference model: playback position is the count of frame_start pulses seen.
    bit m_play = 0, m_cool = 0;
    int m_x0 = 0, m_y0 = 0, m_pulses = 0;
    int e_addr = 0, e_pal = 0;
    bit e_pen = 0, e_v1 = 0, e_busy = 0, e_done = 0;
    int frm, px, py;
    bit inb;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_play = 0; m_cool = 0; m_x0 = 0; m_y0 = 0; m_pulses = 0;
            e_addr = 0; e_pal = 0; e_pen = 0; e_v1 = 0;
        end else begin
            e_pen = e_v1 && rom_index != 4'd0 && rom_index != 4'd11;
            e_pal = int'(rom_index);
            frm = m_pulses / TPF;
            px = int'(DrawX);
            py = int'(DrawY);
            inb = px >= m_x0 && px < m_x0 + FW && py >= m_y0 && py < m_y0 + FH;
            e_v1 = inb && m_play;
            e_addr = inb ? ((frm * FW * FH + (py - m_y0) * FW + (px - m_x0)) % (1 << AW)) : 0;
            if (m_cool) begin
                m_cool = 0;
            end else if (m_play) begin
                if (stop) begin
                    m_play = 0; m_cool = 1;
                end else if (frame_start) begin
                    m_pulses++;
                    if (m_pulses == FRAMES * TPF) begin
`ifdef VENOM_LOOP_EN
                        m_pulses = 0;
`else
                        m_play = 0; m_cool = 1;
`endif
                    end
                end
            end else if (fire) begin
                m_play = 1; m_x0 = int'(x_origin); m_y0 = int'(y_origin); m_pulses = 0;
            end
        end
        e_busy = m_play;
        e_done = m_cool;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("rom_addr", int'(rom_addr), e_addr);
            chk("pal_index", int'(pal_index), e_pal);
            chk("pixel_en", int'(pixel_en), int'(e_pen));
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet();
        fire = 0; stop = 0; frame_start = 0;
        x_origin = 0; y_origin = 0;
        DrawX = 10'd500; DrawY = 10'd400; rom_index = 0;
    endtask

    // Present one scan position, then feed ROM data on the following cycle.
    task automatic issue(input int x, input int y, input int ri);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        got_addr = int'(rom_addr);
        rom_index = 4'(ri);
        DrawX = 10'd500; DrawY = 10'd400;
        step();
        rom_index = 0;
    endtask

    task automatic pulse();
        frame_start = 1;
        step();
        frame_start = 0;
    endtask

    task automatic start(input int x, input int y);
        x_origin = 10'(x); y_origin = 10'(y); fire = 1;
        step();
        fire = 0; x_origin = 0; y_origin = 0;
    endtask

    initial begin
        Reset_n = 1;
        quiet();
        #1 Reset_n = 0;
        chk_on = 1;
        repeat (6) begin
            step();
            fire = 1'($urandom); stop = 1'($urandom); frame_start = 1'($urandom);
            x_origin = 10'($urandom_range(0, 1023)); y_origin = 10'($urandom_range(0, 1023));
            DrawX = 10'($urandom_range(0, 1023)); DrawY = 10'($urandom_range(0, 1023));
            rom_index = 4'($urandom_range(0, 15));
        end
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_pen", int'(pixel_en), 0);
        quiet();
        step();
        Reset_n = 1;
        repeat (3) step();
        chk("post_rst_addr", int'(rom_addr), 0);
        chk("post_rst_done", int'(done), 0);

        // full run from origin (100,50)
        start(100, 50);
        chk("fire_busy", int'(busy), 1);
        for (int i = 0; i < 32; i++) begin
            if (i == 8) begin
                issue(110, 53, 7);
                chk("addr_f2", got_addr, 2154);
                chk("pal_f2", int'(pal_index), 7);
                chk("pen_f2", int'(pixel_en), 1);
                issue(101, 50, 0);
                chk("pen_key0", int'(pixel_en), 0);
                issue(102, 50, 11);
                chk("pen_key11", int'(pixel_en), 0);
                chk("pal_key11", int'(pal_index), 11);
            end
            pulse();
            if (i == 31) begin
`ifdef VENOM_LOOP_EN
                chk("wrap_busy", int'(busy), 1);
`else
                chk("end_done", int'(done), 1);
                chk("end_busy", int'(busy), 0);
`endif
            end
            step();
        end
`ifdef VENOM_LOOP_EN
        issue(100, 50, 3);
        chk("wrap_addr", got_addr, 0);
        for (int i = 0; i < 8; i++) begin
            pulse();
            step();
        end
        chk("loop_busy", int'(busy), 1);
        stop = 1;
        step();
        stop = 0;
        chk("loop_done", int'(done), 1);
        chk("loop_busy_off", int'(busy), 0);
        step();
`endif
        chk("done_once", int'(done), 0);
        chk("idle_busy", int'(busy), 0);

        // screen-edge box
        start(1000, 470);
        issue(5, 480, 5);
        chk("edge_out_addr", got_addr, 0);
        chk("edge_out_pen", int'(pixel_en), 0);
        issue(1023, 470, 5);
        chk("edge_in_addr", got_addr, 23);
        chk("edge_in_pen", int'(pixel_en), 1);
        issue(1023, 501, 9);
        chk("edge_corner_addr", got_addr, 1015);
        stop = 1;
        step();
        stop = 0;
        step();

        // stop with frame_start at frame 3, fire ignored while playing
        start(100, 50);
        for (int i = 0; i < 12; i++) begin
            pulse();
            step();
        end
        issue(100, 50, 1);
        chk("f3_addr", got_addr, 3072);
        x_origin = 10'd300; y_origin = 10'd200; fire = 1;
        step();
        fire = 0;
        issue(104, 51, 2);
        chk("refire_addr", got_addr, 3072 + 32 + 4);
        chk("refire_pen", int'(pixel_en), 1);
        stop = 1; frame_start = 1;
        step();
        stop = 0; frame_start = 0;
        chk("stop_done", int'(done), 1);
        chk("stop_busy", int'(busy), 0);
        step();

        // stop in IDLE ignored; fire in DONE ignored
        stop = 1;
        step();
        stop = 0;
        chk("idle_stop", int'(busy), 0);
        start(200, 100);
        stop = 1;
        step();
        stop = 0; fire = 1;
        step();
        fire = 0;
        step();
        chk("done_fire", int'(busy), 0);

        // reset mid-animation
        start(100, 50);
        pulse();
        step();
        Reset_n = 0;
        #2;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        step();
        Reset_n = 1;
        repeat (3) step();

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/venom_anim_ctrl.md
# venom_anim_ctrl

Sequencer for the venom projectile animation. On a fire request it latches a screen origin, steps through a fixed number of sprite frames at a rate set by vertical-sync ticks, and generates the sprite ROM address for each scan position. It also applies colour-key transparency and drives the 4-bit palette index consumed by the venom palette lookup. It sits between the VGA scan counters and the venom sprite ROM and palette, ahead of the colour mapper.

## Interface
Parameters:
- FRAMES, 8: number of animation frames stored back-to-back in ROM.
- FRAME_W, 32: sprite width in pixels.
- FRAME_H, 32: sprite height in pixels.
- TICKS_PER_FRAME, 4: frame_start pulses per animation frame (1..255).
- ADDR_W, 13: ROM address width; must satisfy 2^ADDR_W >= FRAMES*FRAME_W*FRAME_H.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: one-cycle pulse per video frame (vsync).
- fire, in, 1: one-cycle start request.
- stop, in, 1: one-cycle abort request.
- x_origin, in, 10: sprite left edge; latched on an accepted fire.
- y_origin, in, 10: sprite top edge; latched on an accepted fire.
- DrawX, in, 10: current scan X.
- DrawY, in, 10: current scan Y.
- rom_addr, out, ADDR_W: registered address to the synchronous sprite ROM.
- rom_index, in, 4: ROM data, valid one cycle after rom_addr.
- pal_index, out, 4: registered palette index.
- pixel_en, out, 1: registered; sprite pixel is opaque and inside the box.
- busy, out, 1: high in PLAY.
- done, out, 1: one-cycle pulse when the animation ends.

## Operation
- FSM states: IDLE, PLAY, DONE.
- IDLE:
  - fire → PLAY; latch origins; frame=0, tick=0.
  - stop is ignored.
- PLAY:
  - On frame_start: if tick==TICKS_PER_FRAME-1, set tick=0 and advance the frame; otherwise tick+1.
  - Frame advance from FRAMES-1 → DONE. With VENOM_LOOP_EN defined, frame wraps to 0 and the FSM stays in PLAY.
  - stop → DONE. stop has priority over a simultaneous frame_start.
  - fire is ignored; there is no retrigger.
- DONE: done=1 for one cycle, then IDLE. A fire in this cycle is ignored.
- In-box test:
  - X: DrawX >= x0 and DrawX < x0+FRAME_W, compared at 11 bits so there is no 10-bit wrap near the screen edge.
  - Y: same form, using y0 and FRAME_H.
- Address: rom_addr = frame*FRAME_W*FRAME_H + (DrawY-y0)*FRAME_W + (DrawX-x0), truncated to ADDR_W. Computed only when in-box; otherwise rom_addr holds 0.
- Transparency: rom_index values 0 and 11 are colour-key magenta, so pixel_en=0 for them.
- pal_index passes rom_index through one register, including for transparent pixels.
- pixel_en=0 whenever the pipelined in-box flag is 0, or the FSM was not in PLAY when the address was issued.
- Reset values (all outputs and state): state=IDLE, frame=0, tick=0, origins=0, rom_addr=0, pal_index=0, pixel_en=0, busy=0, done=0.
- Asserting Reset_n low mid-animation returns to IDLE immediately; no done pulse.

## Timing
- Scan pipeline:
  - Cycle N: DrawX/DrawY presented.
  - Edge N+1: rom_addr and in-box/valid flag registered.
  - Edge N+2: pal_index and pixel_en registered.
  - Total latency: 2 cycles from DrawX/DrawY to pixel_en/pal_index.
- The valid flag travels with the address, so a pixel issued in the last PLAY cycle still completes.
- fire at cycle N: busy=1 from N+1.
- done is asserted the cycle after the final frame advance or stop, and busy drops in that same cycle.
- Frame and tick change only on cycles where frame_start=1 and state=PLAY.

## Configuration
- VENOM_LOOP_EN defined: the animation loops indefinitely and ends only on stop; done pulses once per stop.
- VENOM_LOOP_EN undefined: plays FRAMES frames once, then DONE. stop still aborts early.

## Test plan
- Reset: hold Reset_n=0 with random inputs → all outputs 0 and state IDLE; release → outputs remain 0.
- Full run: fire with origin (100,50), then 32 frame_start pulses (defaults) → frame steps 0..7 every 4 pulses; done pulses one cycle after the 32nd pulse; busy falls in that same cycle.
- Address: frame 2 active, DrawX=110, DrawY=53 → rom_addr=2*1024+3*32+10=2154 at N+1. Drive rom_index=7 → pal_index=7, pixel_en=1 at N+2.
- Transparency and edge:
  - rom_index=0 or 11 → pixel_en=0.
  - Origin (1000,470), DrawX=5 → out of box, pixel_en=0 (no wrap).
  - DrawX=1023 → in box at offset 23.
- Simultaneous events:
  - stop and frame_start in the same cycle at frame 3 → DONE; frame does not advance.
  - fire during PLAY → origin unchanged.
- Loop: VENOM_LOOP_EN defined, 40 frame_start pulses → frame wraps 7→0 and busy stays 1; stop → done pulse, then IDLE.
